// File: rtl/optical_manchester_rx.sv
// ----------------------------------------------------------------------------
// optical_manchester_rx
//
// Receives a Manchester-coded line from an optical comparator. The receiver
// hunts for an 8-bit sync word, then collects a DATA_WIDTH payload
// (MSB first) and one even-parity bit. A mid-bit rising edge is a 1 and a
// falling edge is a 0.
//
// Ports
//   clk_100mhz  in   1           sole clock, rising edge
//   rst         in   1           synchronous, active-high reset
//   rx_in       in   1           asynchronous Manchester line
//   data_out    out  DATA_WIDTH  last payload whose parity checked good
//   data_valid  out  1           one-cycle pulse: data_out just updated
//   parity_err  out  1           one-cycle pulse: frame failed parity
//   frame_err   out  1           one-cycle pulse: line went quiet mid-frame
//   busy        out  1           high while the receiver is not IDLE
// ----------------------------------------------------------------------------
module optical_manchester_rx #(
    parameter int         HALF_BIT_CLKS = 8,
    parameter int         DATA_WIDTH    = 16,
    parameter logic [7:0] SYNC_WORD     = 8'hD5
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_MAX    = (5 * HALF_BIT_CLKS) / 2;
    localparam int CNT_ACCEPT = (3 * HALF_BIT_CLKS) / 2;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BIT_W      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX_V    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_WARN_V   = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT_V = CNT_W'(CNT_ACCEPT);
    localparam logic [BIT_W-1:0] BIT_LAST_V   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HUNT,
        S_DATA,
        S_PARITY
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic                  r_rx_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_hunt;
    logic [DATA_WIDTH-1:0] r_payload;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;

    logic                  w_edge;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_err_arm;
    logic                  w_parity_ok;
    logic [7:0]            w_hunt_next;

    assign w_edge = r_rx_s ^ r_rx_d;

    // Edges closer than 3/4 bit to the last accepted edge are bit-boundary
    // transitions and carry no data. Once the counter has saturated the
    // frame is considered lost, so late edges are not accepted either.
    assign w_accept = w_edge &&
                      ((r_state == S_IDLE) ||
                       ((r_cnt >= CNT_ACCEPT_V) && (r_cnt != CNT_MAX_V)));

    assign w_timeout = (r_state != S_IDLE) && (r_cnt == CNT_MAX_V);

    // The error pulse is raised on the clock edge where the counter reaches
    // its limit; the state returns to IDLE one cycle later, so busy drops
    // the cycle after frame_err.
    assign w_err_arm = ((r_state == S_DATA) || (r_state == S_PARITY)) &&
                       !w_accept && (r_cnt == CNT_WARN_V);

    assign w_hunt_next = {r_hunt[6:0], r_rx_s};
    assign w_parity_ok = ~(^r_payload ^ r_rx_s);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            // NOTE: the payload/data registers are plain flop vectors, not RAM,
            // so clearing them in reset is cheap and keeps outputs defined.
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_rx_s       <= 1'b0;
            r_rx_d       <= 1'b0;
            r_cnt        <= '0;
            r_hunt       <= '0;
            r_payload    <= '0;
            r_bit_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // Two-flop synchronizer for the asynchronous comparator output.
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;

            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX_V) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hunt  <= w_hunt_next;
                        r_state <= S_HUNT;
                    end
                end

                S_HUNT: begin
                    if (w_accept) begin
                        if (w_hunt_next == SYNC_WORD) begin
                            r_hunt    <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_hunt <= w_hunt_next;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_payload <= {r_payload[DATA_WIDTH-2:0], r_rx_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST_V) begin
                            r_state <= S_PARITY;
                        end
                    end else if (w_err_arm) begin
                        r_frame_err <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end

                S_PARITY: begin
                    if (w_accept) begin
                        if (w_parity_ok) begin
                            r_data_out   <= r_payload;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_parity_err <= 1'b1;
                        end
                        // Re-arm the hunt immediately so a sync word may
                        // follow the parity bit with no preamble.
                        r_hunt  <= '0;
                        r_state <= S_HUNT;
                    end else if (w_err_arm) begin
                        r_frame_err <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_optical_manchester_rx.sv
`timescale 1ns/1ps
// Directed bench for optical_manchester_rx: frames are built as bit queues,
// Manchester-encoded on the fly and driven on falling clock edges.
module tb_optical_manchester_rx;

    localparam int HALF     = 8;
    localparam int DW       = 16;
    localparam int BIT_CLKS = 2 * HALF;

    logic          clk_100mhz = 1'b0;
    logic          rst        = 1'b1;
    logic          rx_in      = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    optical_manchester_rx #(
        .HALF_BIT_CLKS(HALF),
        .DATA_WIDTH   (DW),
        .SYNC_WORD    (8'hD5)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------- monitor
    int            cyc           = 0;
    int            n_valid       = 0;
    int            n_perr        = 0;
    int            n_ferr        = 0;
    int            n_multi       = 0;
    int            valid_cyc     = -1;
    int            perr_cyc      = -1;
    int            ferr_cyc      = -1;
    int            busy_fall_cyc = -1;
    int            last_tx_cyc   = -1;
    logic          prev_busy     = 1'b0;
    logic [DW-1:0] valid_q[$];

    always @(negedge clk_100mhz) begin
        cyc       <= cyc + 1;
        prev_busy <= busy;
        if (data_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
            valid_q.push_back(data_out);
        end
        if (parity_err) begin
            n_perr   <= n_perr + 1;
            perr_cyc <= cyc;
        end
        if (frame_err) begin
            n_ferr   <= n_ferr + 1;
            ferr_cyc <= cyc;
        end
        if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1)
            n_multi <= n_multi + 1;
        if (prev_busy && !busy)
            busy_fall_cyc <= cyc;
    end

    // ------------------------------------------------------- frame building
    bit bits_q[$];

    function automatic void push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
    endfunction

    function automatic void push_word(input logic [DW-1:0] v, input int n_top);
        for (int i = DW - 1; i >= DW - n_top; i--) bits_q.push_back(v[i]);
    endfunction

    function automatic void push_bit(input bit b);
        bits_q.push_back(b);
    endfunction

    // Drives the queued bits: first half ~b, second half b. With jitter on,
    // every transition is displaced by up to +/-2 cycles from nominal.
    // n_emit <= 0 plays the whole queue; otherwise stops after n_emit cycles.
    task automatic send_bits(input int n_emit, input bit jitter);
        int n     = bits_q.size();
        int total = n * BIT_CLKS;
        int limit;
        int e     = 0;
        int ev_t[$];
        bit ev_l[$];
        bit level = rx_in;
        int jm[10] = '{0, 2, 1, -1, -2, 0, 2, 1, -1, -2};
        int jb[4]  = '{2, -2, 1, -1};
        for (int k = 0; k < n; k++) begin
            if ((!bits_q[k]) != level) begin
                ev_t.push_back(k * BIT_CLKS + ((jitter && k > 0) ? jb[k % 4] : 0));
                ev_l.push_back(!bits_q[k]);
            end
            ev_t.push_back(k * BIT_CLKS + HALF + (jitter ? jm[k % 10] : 0));
            ev_l.push_back(bits_q[k]);
            level = bits_q[k];
        end
        limit = (n_emit <= 0 || n_emit > total) ? total : n_emit;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk_100mhz);
            while (e < ev_t.size() && ev_t[e] <= c) begin
                rx_in       = ev_l[e];
                last_tx_cyc = cyc;
                e++;
            end
        end
        bits_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    // Return the line to low and let any hunt time out.
    task automatic settle();
        @(negedge clk_100mhz);
        rx_in = 1'b0;
        wait_cycles(60);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data_out: got %h want %h", data_out, 16'h0000);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if ({data_valid, parity_err, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 000", {data_valid, parity_err, frame_err});
        end
        rst = 1'b0;
        wait_cycles(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_good_frame();
        int v0, p0, f0;
        settle();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'hA5C3, DW); push_bit(1'b0);
        send_bits(0, 1'b0);
        wait_cycles(10);
        checks++;
        if (n_valid !== v0 + 1) begin
            errors++;
            $display("FAIL good_valid_count: got %0d want %0d", n_valid - v0, 1);
        end
        checks++;
        if (data_out !== 16'hA5C3) begin
            errors++;
            $display("FAIL good_data: got %h want %h", data_out, 16'hA5C3);
        end
        checks++;
        if (valid_cyc !== last_tx_cyc + 3) begin
            errors++;
            $display("FAIL good_latency: got %0d want %0d", valid_cyc - last_tx_cyc, 3);
        end
        checks++;
        if (n_perr !== p0 || n_ferr !== f0) begin
            errors++;
            $display("FAIL good_no_err: got perr %0d ferr %0d want 0 0", n_perr - p0, n_ferr - f0);
        end
    endtask

    task automatic test_parity_error();
        int v0, p0, f0;
        settle();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'hA5C3, DW); push_bit(1'b1);
        send_bits(0, 1'b0);
        wait_cycles(10);
        checks++;
        if (n_perr !== p0 + 1) begin
            errors++;
            $display("FAIL parity_err_count: got %0d want %0d", n_perr - p0, 1);
        end
        checks++;
        if (perr_cyc !== last_tx_cyc + 3) begin
            errors++;
            $display("FAIL parity_latency: got %0d want %0d", perr_cyc - last_tx_cyc, 3);
        end
        checks++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            errors++;
            $display("FAIL parity_no_valid: got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0);
        end
        checks++;
        if (data_out !== 16'hA5C3) begin
            errors++;
            $display("FAIL parity_data_kept: got %h want %h", data_out, 16'hA5C3);
        end
    endtask

    task automatic test_signal_loss();
        int v0, p0, f0;
        settle();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'hA5C3, 7);
        send_bits(0, 1'b0);
        wait_cycles(40);
        checks++;
        if (n_ferr !== f0 + 1) begin
            errors++;
            $display("FAIL loss_ferr_count: got %0d want %0d", n_ferr - f0, 1);
        end
        // rx_in edge -> counter cleared 3 clocks later -> 20 counts to limit.
        checks++;
        if (ferr_cyc !== last_tx_cyc + 23) begin
            errors++;
            $display("FAIL loss_ferr_time: got %0d want %0d", ferr_cyc - last_tx_cyc, 23);
        end
        checks++;
        if (busy_fall_cyc !== last_tx_cyc + 24) begin
            errors++;
            $display("FAIL loss_busy_fall: got %0d want %0d", busy_fall_cyc - last_tx_cyc, 24);
        end
        checks++;
        if (n_valid !== v0 || n_perr !== p0) begin
            errors++;
            $display("FAIL loss_no_other: got valid %0d perr %0d want 0 0", n_valid - v0, n_perr - p0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, p0, f0, q0;
        settle();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr; q0 = valid_q.size();
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'h0001, DW); push_bit(1'b1);
        push_byte(8'hD5); push_word(16'hFFFE, DW); push_bit(1'b1);
        send_bits(0, 1'b0);
        wait_cycles(10);
        checks++;
        if (n_valid !== v0 + 2) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d want %0d", n_valid - v0, 2);
        end
        checks++;
        if (valid_q.size() < q0 + 2) begin
            errors++;
            $display("FAIL b2b_order: got %0d frames want 2", valid_q.size() - q0);
        end else if (valid_q[q0] !== 16'h0001 || valid_q[q0 + 1] !== 16'hFFFE) begin
            errors++;
            $display("FAIL b2b_order: got %h,%h want 0001,fffe", valid_q[q0], valid_q[q0 + 1]);
        end
        checks++;
        if (n_perr !== p0 || n_ferr !== f0) begin
            errors++;
            $display("FAIL b2b_no_err: got perr %0d ferr %0d want 0 0", n_perr - p0, n_ferr - f0);
        end
    endtask

    task automatic test_jitter();
        int v0, p0, f0;
        settle();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'h1234, DW); push_bit(1'b1);
        send_bits(0, 1'b1);
        wait_cycles(10);
        checks++;
        if (n_valid !== v0 + 1) begin
            errors++;
            $display("FAIL jitter_valid_count: got %0d want %0d", n_valid - v0, 1);
        end
        checks++;
        if (data_out !== 16'h1234) begin
            errors++;
            $display("FAIL jitter_data: got %h want %h", data_out, 16'h1234);
        end
        checks++;
        if (n_perr !== p0 || n_ferr !== f0) begin
            errors++;
            $display("FAIL jitter_no_err: got perr %0d ferr %0d want 0 0", n_perr - p0, n_ferr - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, p0, f0;
        settle();
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'h5A3C, DW); push_bit(1'b0);
        // 24 bits precede payload bit 9; stop 12 cycles into it.
        send_bits(24 * BIT_CLKS + 12, 1'b0);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b want 1", busy);
        end
        @(negedge clk_100mhz);
        rst   = 1'b1;
        rx_in = 1'b0;
        @(negedge clk_100mhz);
        rst = 1'b0;
        checks++;
        if ({data_out, busy, data_valid, parity_err, frame_err} !== {(DW + 4){1'b0}}) begin
            errors++;
            $display("FAIL midrst_outputs: got data %h busy %b pulses %b want 0",
                     data_out, busy, {data_valid, parity_err, frame_err});
        end
        wait_cycles(60);
        checks++;
        if (n_valid !== v0 || n_perr !== p0 || n_ferr !== f0) begin
            errors++;
            $display("FAIL midrst_no_pulse: got valid %0d perr %0d ferr %0d want 0 0 0",
                     n_valid - v0, n_perr - p0, n_ferr - f0);
        end
        push_byte(8'hAA); push_byte(8'hD5); push_word(16'h5A3C, DW); push_bit(1'b0);
        send_bits(0, 1'b0);
        wait_cycles(10);
        checks++;
        if (data_out !== 16'h5A3C || n_valid !== v0 + 1) begin
            errors++;
            $display("FAIL midrst_recover: got %h (%0d valid) want %h (1 valid)",
                     data_out, n_valid - v0, 16'h5A3C);
        end
    endtask

    task automatic test_exclusive_pulses();
        checks++;
        if (n_multi !== 0) begin
            errors++;
            $display("FAIL exclusive_pulses: got %0d cycles with >1 pulse want 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_signal_loss();
        test_back_to_back();
        test_jitter();
        test_reset_mid_frame();
        test_exclusive_pulses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
